// File: rtl/mtsp_launch.sv
// mtsp_launch: launch sequencer and per-core busy tracker for the MTSP array.
// Optional watchdog: define MTSP_LAUNCH_TIMEOUT_EN to enable the RUN timeout.
`ifndef MEITNER_CORE_SIZE
`define MEITNER_CORE_SIZE 4
`endif

module mtsp_launch #(
  parameter int CORE_SIZE      = `MEITNER_CORE_SIZE,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 LAUNCH_VALID,
  input  logic [CORE_SIZE-1:0] LAUNCH_MASK,
  output logic                 LAUNCH_READY,
  output logic [CORE_SIZE-1:0] CORE_START,
  input  logic [CORE_SIZE-1:0] CORE_BUSY,
  output logic [CORE_SIZE-1:0] ACTIVE,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 DONE_TIMEOUT
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CORE_SIZE-1:0] r_mask;
  logic [CORE_SIZE-1:0] r_seen;
  logic [CORE_SIZE-1:0] r_fin;
  logic [CORE_SIZE-1:0] w_mask_nxt;
  logic [CORE_SIZE-1:0] w_seen_nxt;
  logic [CORE_SIZE-1:0] w_fin_nxt;

  logic                 r_ready;
  logic [CORE_SIZE-1:0] r_start;
  logic [CORE_SIZE-1:0] r_active;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_timeout;

  logic w_accept;
  logic w_to_hit;
  logic w_timeout_nxt;

`ifdef MTSP_LAUNCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] r_cnt;

  // Watchdog counter: held at zero outside RUN, counts RUN cycles.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_cnt <= '0;
    end else if (r_state != S_RUN) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_to_hit = (r_state == S_RUN) &&
                    (r_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign w_to_hit = 1'b0;
`endif

  assign w_accept = LAUNCH_VALID && r_ready;

  // State register plus latched mask and per-core progress bits.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= S_IDLE;
      r_mask  <= '0;
      r_seen  <= '0;
      r_fin   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mask  <= w_mask_nxt;
      r_seen  <= w_seen_nxt;
      r_fin   <= w_fin_nxt;
    end
  end

  // Next-state and tracking; completion is judged on the
  // updated fin so DONE lands the cycle after the last fall.
  always_comb begin
    w_state_nxt   = r_state;
    w_mask_nxt    = r_mask;
    w_seen_nxt    = r_seen;
    w_fin_nxt     = r_fin;
    w_timeout_nxt = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_mask_nxt = LAUNCH_MASK;
          w_seen_nxt = '0;
          w_fin_nxt  = '0;
          if (LAUNCH_MASK == '0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_START;
          end
        end
      end
      S_START: begin
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_seen_nxt = r_seen | (r_mask & CORE_BUSY);
        w_fin_nxt  = r_fin |
                     (r_mask & r_seen & ~CORE_BUSY);
        if (w_fin_nxt == r_mask) begin
          w_state_nxt = S_DONE;
        end else if (w_to_hit) begin
          w_state_nxt   = S_DONE;
          w_timeout_nxt = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered outputs derived from the upcoming state.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_ready   <= 1'b0;
      r_start   <= '0;
      r_active  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_ready   <= (w_state_nxt == S_IDLE) &&
                   (CORE_BUSY == '0);
      r_start   <= (w_state_nxt == S_START) ?
                   w_mask_nxt : '0;
      r_active  <= ((w_state_nxt == S_START) ||
                    (w_state_nxt == S_RUN)) ?
                   (w_mask_nxt & ~w_fin_nxt) : '0;
      r_busy    <= (w_state_nxt != S_IDLE);
      r_done    <= (w_state_nxt == S_DONE);
      r_timeout <= w_timeout_nxt;
    end
  end

  assign LAUNCH_READY = r_ready;
  assign CORE_START   = r_start;
  assign ACTIVE       = r_active;
  assign BUSY         = r_busy;
  assign DONE         = r_done;
  assign DONE_TIMEOUT = r_timeout;

endmodule

// File: tb/tb_mtsp_launch.sv
// tb_mtsp_launch: scoreboard bench for mtsp_launch.
// Start and done events are queued at accept and popped by a monitor.
module tb_mtsp_launch;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       LAUNCH_VALID;
  logic [3:0] LAUNCH_MASK;
  logic       LAUNCH_READY;
  logic [3:0] CORE_START;
  logic [3:0] CORE_BUSY;
  logic [3:0] ACTIVE;
  logic       BUSY;
  logic       DONE;
  logic       DONE_TIMEOUT;

  mtsp_launch #(
    .CORE_SIZE(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .LAUNCH_VALID(LAUNCH_VALID),
    .LAUNCH_MASK(LAUNCH_MASK),
    .LAUNCH_READY(LAUNCH_READY),
    .CORE_START(CORE_START),
    .CORE_BUSY(CORE_BUSY),
    .ACTIVE(ACTIVE),
    .BUSY(BUSY),
    .DONE(DONE),
    .DONE_TIMEOUT(DONE_TIMEOUT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int       cyc;
    logic [3:0] v;
  } ev_t;

  ev_t exp_start[$];
  ev_t exp_done[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int t0    = 0;
  int lo[4];
  int hi[4];
  logic [3:0] tog = 4'b0;
  int tog_end = 0;
  logic [3:0] ovr = 4'b0;
  bit sched_on = 1'b0;
  int act_rel = -1;
  logic [3:0] act_val = 4'b0;
  int d_cyc;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_busy();
    logic [3:0] b;
    for (int i = 0; i < 4; i++) begin
      b[i] = sched_on && (cyc >= t0 + lo[i]) && (cyc <= t0 + hi[i]);
      if (sched_on && tog[i] && cyc >= t0 + 2 && cyc < t0 + tog_end)
        b[i] = cyc[0];
    end
    CORE_BUSY = b | ovr;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    drive_busy();
  endtask

  task automatic set_sched(input int l0, input int h0,
                           input int l1, input int h1,
                           input int l2, input int h2,
                           input int l3, input int h3);
    lo[0] = l0; hi[0] = h0;
    lo[1] = l1; hi[1] = h1;
    lo[2] = l2; hi[2] = h2;
    lo[3] = l3; hi[3] = h3;
  endtask

  task automatic do_launch(input logic [3:0] m,
                           input int doff,
                           input bit to);
    int n;
    n = 0;
    LAUNCH_MASK  = m;
    LAUNCH_VALID = 1'b1;
    while (!LAUNCH_READY && n < 40) begin
      tick();
      n++;
    end
    if (!LAUNCH_READY) begin
      chk("accept_wait", 32'd0, 32'd1);
      LAUNCH_VALID = 1'b0;
      return;
    end
    t0 = cyc;
    sched_on = 1'b1;
    if (m != 4'b0) exp_start.push_back('{t0 + 1, m});
    exp_done.push_back('{t0 + doff, {3'b0, to}});
    tick();
    LAUNCH_VALID = 1'b0;
    while (cyc <= t0 + doff + 1) begin
      if (cyc == t0 + 1) chk("busy_flag", 32'(BUSY), 32'd1);
      if (cyc == t0 + act_rel) chk("active", 32'(ACTIVE), 32'(act_val));
      if (cyc == t0 + doff + 1)
        chk("ready_after", 32'(LAUNCH_READY), 32'd1);
      tick();
    end
    sched_on  = 1'b0;
    tog       = 4'b0;
    act_rel   = -1;
    CORE_BUSY = ovr;
    chk("done_pending", 32'(exp_done.size()), 32'd0);
  endtask

  always @(negedge CLK) begin : mon
    ev_t e;
    if (CORE_START != 4'b0) begin
      if (exp_start.size() == 0) begin
        chk("start_unexp", 32'(CORE_START), 32'd0);
      end else begin
        e = exp_start.pop_front();
        chk("start_cyc", 32'(cyc), 32'(e.cyc));
        chk("start_mask", 32'(CORE_START), 32'(e.v));
      end
    end
    if (DONE) begin
      if (exp_done.size() == 0) begin
        chk("done_unexp", 32'(DONE), 32'd0);
      end else begin
        e = exp_done.pop_front();
        chk("done_cyc", 32'(cyc), 32'(e.cyc));
        chk("done_to", 32'(DONE_TIMEOUT), 32'(e.v[0]));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_sched(1000, 0, 1000, 0, 1000, 0, 1000, 0);
    nRST         = 1'b0;
    LAUNCH_VALID = 1'b1;
    LAUNCH_MASK  = 4'b0001;
    CORE_BUSY    = 4'b0;

    repeat (3) begin
      tick();
      chk("rst_out",
          {18'b0, LAUNCH_READY, BUSY, DONE, DONE_TIMEOUT,
           CORE_START, ACTIVE, 2'b0},
          32'd0);
    end
    nRST = 1'b1;
    tick();
    chk("ready_rel", 32'(LAUNCH_READY), 32'd1);
    chk("busy_rel", 32'(BUSY), 32'd0);
    LAUNCH_VALID = 1'b0;
    tick();

    set_sched(2, 4, 1000, 0, 3, 9, 1000, 0);
    act_rel = 6;
    act_val = 4'b0100;
    do_launch(4'b0101, 11, 1'b0);

    set_sched(1000, 0, 1000, 0, 1000, 0, 1000, 0);
    do_launch(4'b0000, 1, 1'b0);

    set_sched(2, 2, 2, 2, 2, 2, 2, 2);
    act_rel = 1;
    act_val = 4'b1111;
    do_launch(4'b1111, 4, 1'b0);

    ovr = 4'b1000;
    tick();
    tick();
    LAUNCH_MASK  = 4'b0001;
    LAUNCH_VALID = 1'b1;
    tick();
    chk("ready_core3", 32'(LAUNCH_READY), 32'd0);
    tick();
    chk("ready_core3b", 32'(LAUNCH_READY), 32'd0);
    ovr       = 4'b0;
    CORE_BUSY = 4'b0;
    d_cyc     = cyc;
    set_sched(2, 3, 1000, 0, 1000, 0, 1000, 0);
    do_launch(4'b0001, 5, 1'b0);
    chk("accept_cyc", 32'(t0), 32'(d_cyc + 1));

    set_sched(2, 3, 1000, 0, 1000, 0, 1000, 0);
    tog     = 4'b0010;
    tog_end = 5;
    do_launch(4'b0001, 5, 1'b0);

    LAUNCH_MASK  = 4'b0011;
    LAUNCH_VALID = 1'b1;
    begin : wait_rdy
      int n;
      n = 0;
      while (!LAUNCH_READY && n < 40) begin
        tick();
        n++;
      end
    end
    chk("ready_mid", 32'(LAUNCH_READY), 32'd1);
    t0 = cyc;
    set_sched(2, 5, 2, 5, 1000, 0, 1000, 0);
    sched_on = 1'b1;
    exp_start.push_back('{t0 + 1, 4'b0011});
    tick();
    LAUNCH_VALID = 1'b0;
    tick();
    tick();
    chk("active_mid", 32'(ACTIVE), 32'd3);
    nRST = 1'b0;
    tick();
    chk("rst_mid", {26'b0, BUSY, DONE, ACTIVE}, 32'd0);
    nRST      = 1'b1;
    sched_on  = 1'b0;
    CORE_BUSY = 4'b0;
    tick();
    tick();

    set_sched(2, 3, 2, 5, 1000, 0, 1000, 0);
    do_launch(4'b0011, 7, 1'b0);

`ifdef MTSP_LAUNCH_TIMEOUT_EN
    set_sched(1000, 0, 1000, 0, 1000, 0, 1000, 0);
    do_launch(4'b0001, 18, 1'b1);
`endif

    tick();
    tick();
    chk("start_left", 32'(exp_start.size()), 32'd0);
    chk("done_left", 32'(exp_done.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
